move_collector: RTL and testbench
=================================

# move_collector

Drains the per-square move FIFOs filled by the square units and serializes every valid 19-bit move into a single valid/ready stream for the downstream move list / evaluator. It round-robins over NSRC sources, pops one 152-bit word (8 move slots) at a time, and discards slots whose invalid flag is set. It signals completion of a board once every source reports done with an empty FIFO.

## Interface
- NSRC, 8, number of square-unit FIFOs served (1..64)
- MVW, 19, move width: [7b flag][6b from][6b to], flag bit 6 (word bit 18) = invalid
- SLOTS, 8, moves per FIFO word (word width = SLOTS*MVW = 152)

- clk  in  1  clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- start  in  1  new board: abort current work, clear counters, begin collection
- src_data  in  NSRC*152  FIFO read data; source i at [i*152 +: 152]
- src_empty  in  NSRC  FIFO empty per source
- src_done  in  NSRC  square-unit done per source
- src_rden  out  NSRC  one-hot FIFO read-enable pulse
- mv_valid  out  1  move available on mv_data
- mv_data  out  19  move, stable while mv_valid && !mv_ready
- mv_ready  in  1  consumer accepts move when high with mv_valid
- busy  out  1  high in any state except IDLE
- finished  out  1  one-cycle pulse: board collection complete
- move_count  out  8  moves emitted this board (see Configuration)

## Operation
- States: IDLE, SCAN, READ, CAPTURE, EMIT, FIN.
- IDLE: wait for start -> SCAN, pointer p=0.
- SCAN: if src_empty[p]==0 -> READ. Else if &src_done && &src_empty and output register empty (mv_valid==0) -> FIN. Else p = (p+1) mod NSRC (wrap NSRC-1 -> 0).
- READ: src_rden[p]=1 for exactly this cycle (combinational from state and p) -> CAPTURE.
- CAPTURE: latch src_data[p] into 152-bit buffer; k=0 -> EMIT.
- EMIT: slot k = buffer[151-19k -: 19] (slot 0 = MSBs). Each cycle where output register is free (!mv_valid || mv_ready): if slot bit 18 == 0 load mv_data, set mv_valid, increment count; else clear mv_valid (skip); k++. After k==7 processed -> SCAN with p = (p+1) mod NSRC. When output register not free, hold k.
- Output register drains independently: mv_valid clears on mv_ready when no new load occurs that cycle.
- FIN: finished=1 for one cycle -> IDLE.
- start in any state (including EMIT with mv_valid high): next cycle mv_valid=0, buffer discarded, p=0, count=0, state SCAN. start in IDLE same.
- All-invalid word: 8 EMIT cycles, no output, no count change.
- move_count saturates at 255.
- src_done is sampled only in SCAN; done deasserted by a square unit (hold/new board) keeps collector scanning.

## Timing
- Reset (reset_n low at edge): state IDLE, p=0, mv_valid=0, mv_data=0, src_rden=0, busy=0, finished=0, move_count=0.
- FIFO read latency 1: data valid the cycle after src_rden.
- SCAN sees non-empty at cycle N: src_rden[p] high in N+1, buffer latched at end of N+2, first mv_valid at N+4 if slot 0 valid.
- Throughput: one move per cycle with mv_ready held high; full word with 8 valid slots -> 8 consecutive mv_valid cycles.
- Per-word overhead: 3 cycles (SCAN, READ, CAPTURE) plus 8 EMIT cycles minimum.
- At most one src_rden bit high in any cycle; never high outside READ.
- finished occurs no earlier than one cycle after the last move handshake.

## Configuration
- MOVE_COLLECTOR_COUNT_EN defined: 8-bit saturating move_count implemented, cleared on reset and start, increments on each loaded valid move.
- Not defined: counter logic omitted, move_count tied to 8'd0.

## Test plan
- Reset: reset_n low 2 cycles with start high -> all outputs 0, state IDLE, no src_rden.
- Single source p=2 non-empty, word with slots 0,3 valid (e.g. 19'h0_2A1C, 19'h0_0451), others 19'h40000, mv_ready=1 -> src_rden=8'b00000100 one cycle, exactly 2 moves in slot order, move_count=2.
- Backpressure: 8 valid slots, mv_ready low 5 cycles after first mv_valid -> mv_data stable throughout, all 8 emitted in order, none dropped or duplicated.
- Wrap and completion: sources 7 and 0 non-empty, start at p=0 after pop of 7 -> order 0 then 7; then all empty, src_done=8'hFF -> single finished pulse, busy falls next cycle.
- All-invalid word (every slot bit 18 set) -> no mv_valid, pointer advances, count unchanged.
- start asserted mid-EMIT with mv_valid high -> mv_valid 0 next cycle, move_count 0, scan restarts at p=0; with macro undefined move_count stays 0 throughout.

Source files
------------

// File: rtl/move_collector.sv
// move_collector: round-robin drain of per-square move FIFOs into one valid/ready move stream; MOVE_COLLECTOR_COUNT_EN adds a saturating move_count
module move_collector #(
  parameter int NSRC = 8,
  parameter int MVW = 19,
  parameter int SLOTS = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [NSRC*SLOTS*MVW-1:0] src_data,
  input  logic [NSRC-1:0]           src_empty,
  input  logic [NSRC-1:0]           src_done,
  output logic [NSRC-1:0]           src_rden,
  output logic                      mv_valid,
  output logic [MVW-1:0]            mv_data,
  input  logic                      mv_ready,
  output logic                      busy,
  output logic                      finished,
  output logic [7:0]                move_count
);
  localparam int WW = SLOTS * MVW;
  localparam int PW = NSRC > 1 ? $clog2(NSRC) : 1;
  localparam int KW = SLOTS > 1 ? $clog2(SLOTS) : 1;
  typedef enum logic [2:0] {IDLE, SCAN, READ, CAPTURE, EMIT, FIN} state_t;
  state_t state, state_nx;
  logic [PW-1:0] p, p_inc;
  logic [KW-1:0] k;
  logic [WW-1:0] buffer;
  logic [WW-1:0] words [NSRC];
  logic [MVW-1:0] slots [SLOTS];
  logic [MVW-1:0] slot;
  logic free, last, load, take;
  for (genvar i = 0; i < NSRC; i++) begin : g_src
    assign words[i] = src_data[i*WW +: WW];
  end
  // slot 0 sits in the most significant bits of the word
  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    assign slots[i] = buffer[(SLOTS-1-i)*MVW +: MVW];
  end
  assign slot = slots[k];
  assign free = !mv_valid || mv_ready;
  assign last = k == KW'(SLOTS - 1);
  assign load = state == EMIT && free;
  assign take = load && !slot[MVW-1];
  assign p_inc = p == PW'(NSRC - 1) ? '0 : p + 1'b1;
  assign busy = state != IDLE;
  assign finished = state == FIN;
  always_comb begin
    state_nx = state;
    src_rden = '0;
    case (state)
      SCAN: state_nx = !src_empty[p] ? READ : (&src_done && &src_empty && !mv_valid) ? FIN : SCAN;
      READ: begin
        state_nx = CAPTURE;
        src_rden[p] = 1'b1;
      end
      CAPTURE: state_nx = EMIT;
      EMIT: state_nx = free && last ? SCAN : EMIT;
      default: state_nx = IDLE;
    endcase
    if (start) state_nx = SCAN;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      p <= '0;
      k <= '0;
      buffer <= '0;
      mv_valid <= 1'b0;
      mv_data <= '0;
    end else begin
      state <= state_nx;
      if (start) begin
        p <= '0;
        k <= '0;
        mv_valid <= 1'b0;
      end else begin
        if (state == SCAN && state_nx == SCAN) p <= p_inc;
        if (state == CAPTURE) begin
          buffer <= words[p];
          k <= '0;
        end
        // an invalid slot still consumes an EMIT cycle and frees the output register
        if (load) begin
          mv_valid <= take;
          if (take) mv_data <= slot;
          k <= k + 1'b1;
          if (last) p <= p_inc;
        end else if (mv_ready) begin
          mv_valid <= 1'b0;
        end
      end
    end
  end
`ifdef MOVE_COLLECTOR_COUNT_EN
  logic [7:0] count;
  always_ff @(posedge clk) begin
    if (!reset_n || start) count <= '0;
    else if (take && count != 8'hFF) count <= count + 1'b1;
  end
  assign move_count = count;
`else
  assign move_count = 8'd0;
`endif
endmodule

// File: tb/tb_move_collector.sv
// tb_move_collector: vector table plus hand sequences against move_collector, with FIFO model and move scoreboard
module tb_move_collector;
  localparam int NSRC = 8;
  localparam int MVW = 19;
  localparam int SLOTS = 8;
  localparam int WW = SLOTS * MVW;
  localparam logic [MVW-1:0] INV = 19'h40000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic mv_ready = 1'b0;
  logic [NSRC*WW-1:0] src_data;
  logic [NSRC-1:0] src_empty;
  logic [NSRC-1:0] src_done = '0;
  logic [NSRC-1:0] src_rden;
  logic mv_valid, busy, finished;
  logic [MVW-1:0] mv_data;
  logic [7:0] move_count;

  always #5 clk = ~clk;

  move_collector #(.NSRC(NSRC), .MVW(MVW), .SLOTS(SLOTS)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .src_data(src_data),
    .src_empty(src_empty), .src_done(src_done), .src_rden(src_rden),
    .mv_valid(mv_valid), .mv_data(mv_data), .mv_ready(mv_ready),
    .busy(busy), .finished(finished), .move_count(move_count)
  );

  logic [WW-1:0] mem [NSRC][16];
  logic [WW-1:0] dout [NSRC];
  logic [3:0] head [NSRC];
  logic [3:0] tail [NSRC];

  always @(posedge clk)
    for (int i = 0; i < NSRC; i++)
      if (!reset_n) head[i] <= '0;
      else if (src_rden[i]) begin
        dout[i] <= mem[i][head[i]];
        head[i] <= head[i] + 1'b1;
      end

  always_comb
    for (int i = 0; i < NSRC; i++) begin
      src_empty[i] = head[i] == tail[i];
      src_data[i*WW +: WW] = dout[i];
    end

  int total = 0, bad = 0;
  logic [MVW-1:0] exp_q [$];
  int exp_cnt = 0, hs = 0, cyc = 0, last_hs = 0, fin_n = 0, rden_n = 0;
  logic [NSRC-1:0] rden_seen = '0;
  logic pv = 1'b0, pr = 1'b0, ps = 1'b0;
  logic [MVW-1:0] pd = '0;

  typedef struct {
    int src;
    logic [WW-1:0] word;
    int n;
    logic [NSRC-1:0] rden;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h", n, a, e);
    end
  endtask

  function automatic int cnt_exp();
`ifdef MOVE_COLLECTOR_COUNT_EN
    return exp_cnt;
`else
    return 0;
`endif
  endfunction

  task automatic mon();
    if (src_rden != '0) begin
      chk("rden_onehot", $countones(src_rden), 1);
      rden_seen |= src_rden;
      rden_n++;
    end
    if (pv && !pr && !ps) begin
      chk("hold_valid", mv_valid, 1);
      chk("hold_data", mv_data, pd);
    end
    if (mv_valid && mv_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_move got=%h want=none", mv_data);
      end else chk("move", mv_data, exp_q.pop_front());
      hs++;
      last_hs = cyc;
    end
    if (finished) fin_n++;
    pv = mv_valid;
    pr = mv_ready;
    pd = mv_data;
    ps = start;
    cyc++;
  endtask

  task automatic step();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input int s, input logic [WW-1:0] w);
    logic [MVW-1:0] sl;
    mem[s][tail[s]] = w;
    tail[s] = tail[s] + 1'b1;
    for (int j = 0; j < SLOTS; j++) begin
      sl = w[WW-1-MVW*j -: MVW];
      if (!sl[MVW-1]) begin
        exp_q.push_back(sl);
        if (exp_cnt < 255) exp_cnt++;
      end
    end
  endtask

  task automatic restart_model();
    exp_q.delete();
    exp_cnt = 0;
  endtask

  task automatic drain(input string n, input int budget);
    int t = 0;
    while ((exp_q.size() != 0 || src_empty != '1) && t < budget) begin
      step();
      t++;
    end
    total++;
    if (t >= budget) begin
      bad++;
      $display("FAIL %s_timeout got=%0d want=0", n, exp_q.size());
    end
    repeat (12) step();
  endtask

  task automatic wait_valid(input string n);
    int t = 0;
    while (!mv_valid && t < 50) begin
      step();
      t++;
    end
    total++;
    if (!mv_valid) begin
      bad++;
      $display("FAIL %s_wait got=0 want=1", n);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1);
  end

  initial begin
    logic [WW-1:0] w;
    logic [MVW-1:0] d0;
    int h0, t, fc;
    for (int i = 0; i < NSRC; i++) tail[i] = '0;
    vecs[0] = '{2, {19'h02A1C, INV, INV, 19'h00451, INV, INV, INV, INV}, 2, 8'h04};
    vecs[1] = '{5, {19'h11111, 19'h22222, 19'h33333, 19'h01234, 19'h05678, 19'h09ABC, 19'h0DEF0, 19'h3FFFF}, 8, 8'h20};
    vecs[2] = '{1, {INV, 19'h7FFFF, 19'h40123, INV, 19'h5ABCD, INV, 19'h7FFFF, INV}, 0, 8'h02};
    vecs[3] = '{7, {19'h00001, INV, 19'h00002, INV, 19'h00003, INV, 19'h00004, INV}, 4, 8'h80};
    vecs[4] = '{0, {INV, INV, INV, INV, INV, INV, INV, 19'h00ABC}, 1, 8'h01};
    vecs[5] = '{4, {19'h7FFFF, 19'h3FFFF, INV, 19'h00000, INV, INV, INV, INV}, 2, 8'h10};

    reset_n = 1'b0;
    start = 1'b1;
    step();
    step();
    chk("rst_valid", mv_valid, 0);
    chk("rst_data", mv_data, 0);
    chk("rst_rden", src_rden, 0);
    chk("rst_busy", busy, 0);
    chk("rst_finished", finished, 0);
    chk("rst_count", move_count, 0);
    reset_n = 1'b1;
    start = 1'b0;
    step();
    chk("idle_busy", busy, 0);
    chk("idle_rden", src_rden, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    restart_model();
    chk("start_busy", busy, 1);
    mv_ready = 1'b1;

    for (int v = 0; v < 6; v++) begin
      h0 = hs;
      rden_seen = '0;
      rden_n = 0;
      push_word(vecs[v].src, vecs[v].word);
      drain("vec", 300);
      chk("vec_moves", hs - h0, vecs[v].n);
      chk("vec_rden", rden_seen, vecs[v].rden);
      chk("vec_rden_n", rden_n, 1);
      chk("vec_count", move_count, cnt_exp());
      chk("vec_busy", busy, 1);
    end

    mv_ready = 1'b0;
    h0 = hs;
    push_word(3, {19'h00101, 19'h00202, 19'h00303, 19'h00404, 19'h00505, 19'h00606, 19'h00707, 19'h00808});
    wait_valid("bp");
    d0 = mv_data;
    repeat (4) step();
    chk("bp_valid", mv_valid, 1);
    chk("bp_data", mv_data, d0);
    mv_ready = 1'b1;
    drain("bp", 300);
    chk("bp_moves", hs - h0, 8);
    chk("bp_count", move_count, cnt_exp());

    mv_ready = 1'b0;
    push_word(4, {19'h01010, 19'h02020, 19'h03030, 19'h04040, 19'h05050, 19'h06060, 19'h07070, 19'h08080});
    wait_valid("abort");
    start = 1'b1;
    step();
    start = 1'b0;
    restart_model();
    chk("abort_valid", mv_valid, 0);
    chk("abort_count", move_count, 0);
    chk("abort_busy", busy, 1);
    push_word(2, {19'h0A0A0, INV, INV, INV, INV, INV, INV, 19'h0A0A1});
    push_word(6, {19'h0B0B0, INV, INV, INV, INV, INV, INV, 19'h0B0B1});
    mv_ready = 1'b1;
    drain("abort", 300);
    chk("abort_after_count", move_count, cnt_exp());

    restart_model();
    push_word(0, {19'h0C000, 19'h0C001, INV, INV, INV, INV, INV, INV});
    push_word(7, {19'h0D000, INV, INV, INV, INV, INV, INV, 19'h0D007});
    start = 1'b1;
    step();
    start = 1'b0;
    drain("wrap", 300);
    chk("wrap_count", move_count, cnt_exp());

    restart_model();
    for (int j = 0; j < 33; j++) begin
      for (int s = 0; s < SLOTS; s++) w[WW-1-MVW*s -: MVW] = {1'b0, 6'(j), 6'(s), 6'(j + s)};
      push_word(j % NSRC, w);
    end
    h0 = hs;
    start = 1'b1;
    step();
    start = 1'b0;
    drain("sat", 1000);
    chk("sat_moves", hs - h0, 264);
    chk("sat_count", move_count, cnt_exp());

    fin_n = 0;
    src_done = '1;
    t = 0;
    while (!finished && t < 50) begin
      step();
      t++;
    end
    chk("fin_seen", finished, 1);
    fc = cyc;
    chk("fin_after_hs", fc > last_hs, 1);
    step();
    chk("fin_pulse", finished, 0);
    chk("fin_busy", busy, 0);
    repeat (5) step();
    chk("fin_once", fin_n, 1);
    chk("fin_idle_busy", busy, 0);
    src_done = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
